// File: rtl/audionet_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audionet_pkg
// Description : Shared types and constants for the AudioNet serial TDM domain.
//               FRAME_BITS_DEF - default frame length in bits
//               frame_t        - one frame at the default length
//               tx_state_t     - transmitter control states
// Revision    : 1.0 - initial release
// ============================================================================
package audionet_pkg;

    localparam int FRAME_BITS_DEF = 256;

    typedef logic [FRAME_BITS_DEF-1:0] frame_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tx_state_t;

endpackage : audionet_pkg
`default_nettype wire

// File: rtl/tdm_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tdm_frame_tx
// Description : Parallel-to-serial TDM frame transmitter. Frames arrive on a
//               valid/ready parallel port and leave serially on sdata with a
//               one-bit frame sync on sfs marking the first bit of each frame.
// Ports       : sclk     - serial bit clock (rising edge)
//               rst      - asynchronous active-high reset
//               enable   - continuous framing; low stops at next boundary
//               pvalid   - pdata holds a valid frame
//               pdata    - frame to transmit
//               pready   - frame accepted when pvalid && pready
//               sdata    - registered serial data
//               sfs      - registered frame sync, high on first bit
//               underrun - pulse with sfs when a frame starts with no data
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_frame_tx
    import audionet_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  pvalid,
    input  logic [FRAME_BITS-1:0] pdata,
    output logic                  pready,
    output logic                  sdata,
    output logic                  sfs,
    output logic                  underrun
);

    localparam int              CNT_W    = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    tx_state_t               state_q, state_d;
    logic [CNT_W-1:0]        bcnt_q, bcnt_d;
    logic [FRAME_BITS-1:0]   hold_q, hold_d;
    logic                    hold_full_q, hold_full_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic                    sdata_q, sdata_d;
    logic                    sfs_q, sfs_d;
    logic                    underrun_q, underrun_d;

    logic                    accept;
    logic                    frame_start;
    logic [FRAME_BITS-1:0]   load_frame;
    logic [FRAME_BITS-1:0]   shreg_shift;
    logic                    next_bit;

    assign pready   = !hold_full_q;
    assign accept   = pvalid && !hold_full_q;
    assign sdata    = sdata_q;
    assign sfs      = sfs_q;
    assign underrun = underrun_q;

    // A new frame begins either when leaving IDLE or at the last bit of a
    // running frame; in both cases enable must be high.
    assign frame_start = enable && ((state_q == IDLE) || (bcnt_q == LAST_BIT));

    // The shift register keeps the frame aligned so the bit about to be sent
    // always sits at the transmit end; next_bit is the one after it.
    assign shreg_shift = MSB_FIRST ? {shreg_q[FRAME_BITS-2:0], 1'b0}
                                   : {1'b0, shreg_q[FRAME_BITS-1:1]};
    assign next_bit    = MSB_FIRST ? shreg_q[FRAME_BITS-2] : shreg_q[1];

    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        sdata_d     = sdata_q;
        sfs_d       = 1'b0;
        underrun_d  = 1'b0;
        load_frame  = '0;

        if (accept) begin
            hold_d      = pdata;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                sdata_d = 1'b0;
            end
            RUN: begin
                if (bcnt_q != LAST_BIT) begin
                    bcnt_d  = bcnt_q + 1'b1;
                    shreg_d = shreg_shift;
                    sdata_d = next_bit;
                end else if (!enable) begin
                    state_d = IDLE;
                    bcnt_d  = '0;
                    sdata_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (frame_start) begin
            state_d = RUN;
            bcnt_d  = '0;
            sfs_d   = 1'b1;
            if (hold_full_q) begin
                load_frame  = hold_q;
                hold_full_d = accept;
            end else if (pvalid) begin
                // Bypass: the accepted frame goes straight to the shifter,
                // so the holding register is left untouched.
                load_frame  = pdata;
                hold_d      = hold_q;
                hold_full_d = 1'b0;
            end else begin
                underrun_d  = 1'b1;
            end
            shreg_d = load_frame;
            sdata_d = MSB_FIRST ? load_frame[FRAME_BITS-1] : load_frame[0];
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bcnt_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            sdata_q     <= 1'b0;
            sfs_q       <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            sdata_q     <= sdata_d;
            sfs_q       <= sfs_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule : tdm_frame_tx
`default_nettype wire
